// File: rtl/barker_phase_sequencer.sv
// rtl/barker_phase_sequencer.sv - Barker bi-phase chip sequencer feeding a DDS AXI-Stream config channel.
// Optional macro PULSE_COUNTER_EN adds pulse_count_o and pulse_done_o.
module barker_phase_sequencer #(
   parameter int PINC_BITS           = 30,
   parameter int PERIOD_COUNTER_BITS = 15,
   parameter int CHIP_CNT_BITS       = 16,
   parameter int PHASE_OFFSET_180    = 536870911
) (
   input  logic                           aclk,
   input  logic                           aresetn,
   input  logic                           enable_i,
   input  logic [2:0]                     code_sel_i,
   input  logic [CHIP_CNT_BITS-1:0]       chip_cycles_i,
   input  logic [PERIOD_COUNTER_BITS-1:0] period_i,
   input  logic [PINC_BITS-1:0]           pinc_i,
   output logic [63:0]                    m_axis_config_tdata,
   output logic                           m_axis_config_tvalid,
   input  logic                           m_axis_config_tready,
   output logic                           pulse_o,
   output logic [3:0]                     chip_idx_o,
   output logic                           overrun_o,
   output logic                           busy_o
`ifdef PULSE_COUNTER_EN
   ,
   output logic [31:0]                    pulse_count_o,
   output logic                           pulse_done_o
`endif
);

   localparam int PAD = 32 - PINC_BITS;
   localparam logic [PINC_BITS-1:0] OFF_180 = PINC_BITS'(PHASE_OFFSET_180);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   // Codes are stored left-aligned so chip k is always bit 12 after a shift by k.
   function automatic logic [12:0] code_pattern(input logic [2:0] sel);
      case (sel)
         3'd0:    code_pattern = 13'b1000000000000;
         3'd1:    code_pattern = 13'b1100000000000;
         3'd2:    code_pattern = 13'b1101000000000;
         3'd3:    code_pattern = 13'b1110100000000;
         3'd4:    code_pattern = 13'b1110010000000;
         3'd5:    code_pattern = 13'b1110001001000;
         3'd6:    code_pattern = 13'b1111100110101;
         default: code_pattern = 13'b1000000000000;
      endcase
   endfunction

   function automatic logic [3:0] code_length(input logic [2:0] sel);
      case (sel)
         3'd0:    code_length = 4'd2;
         3'd1:    code_length = 4'd3;
         3'd2:    code_length = 4'd4;
         3'd3:    code_length = 4'd5;
         3'd4:    code_length = 4'd7;
         3'd5:    code_length = 4'd11;
         3'd6:    code_length = 4'd13;
         default: code_length = 4'd1;
      endcase
   endfunction

   state_t                         state_q;
   logic [2:0]                     code_q;
   logic [CHIP_CNT_BITS-1:0]       chip_cycles_q;
   logic [PERIOD_COUNTER_BITS-1:0] period_q;
   logic [PINC_BITS-1:0]           pinc_q;
   logic [CHIP_CNT_BITS-1:0]       chip_cnt_q;
   logic [PERIOD_COUNTER_BITS-1:0] period_cnt_q;
   logic [3:0]                     chip_idx_q;
   logic [63:0]                    tdata_q;
   logic                           tvalid_q;
   logic                           overrun_q;
   logic                           pulse_q;

   logic [CHIP_CNT_BITS-1:0] chip_last_cnt;
   logic                     chip_end;
   logic                     last_chip;
   logic                     period_hit;
   logic                     start_pulse;
   logic                     next_chip;
   logic                     issue;
   logic [2:0]               issue_code;
   logic [3:0]               issue_idx;
   logic [PINC_BITS-1:0]     issue_pinc;
   logic [12:0]              issue_pat;
   logic [PINC_BITS-1:0]     issue_off;
   logic [63:0]              issue_word;

   always_comb begin
      chip_last_cnt = (chip_cycles_q == '0) ? '0 : chip_cycles_q - CHIP_CNT_BITS'(1);
      chip_end      = (state_q == PULSE) && (chip_cnt_q == chip_last_cnt);
      last_chip     = (chip_idx_q == code_length(code_q) - 4'd1);
      period_hit    = ({1'b0, period_cnt_q} + (PERIOD_COUNTER_BITS+1)'(1)) >= {1'b0, period_q};
      // A new pulse starts from IDLE, at period end in GAP, or straight after the last chip when the period is already spent.
      start_pulse   = enable_i && ((state_q == IDLE) || ((state_q == GAP) && period_hit) ||
                                   (chip_end && last_chip && period_hit));
      next_chip     = enable_i && chip_end && !last_chip;
      issue         = start_pulse || next_chip;
      issue_code    = start_pulse ? code_sel_i : code_q;
      issue_idx     = start_pulse ? 4'd0 : chip_idx_q + 4'd1;
      issue_pinc    = start_pulse ? pinc_i : pinc_q;
      issue_pat     = code_pattern(issue_code) << issue_idx;
      issue_off     = issue_pat[12] ? '0 : OFF_180;
      issue_word    = {{PAD{1'b0}}, issue_off, {PAD{1'b0}}, issue_pinc};
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         code_q        <= '0;
         chip_cycles_q <= '0;
         period_q      <= '0;
         pinc_q        <= '0;
         chip_cnt_q    <= '0;
         period_cnt_q  <= '0;
         chip_idx_q    <= '0;
         tdata_q       <= '0;
         tvalid_q      <= 1'b0;
         overrun_q     <= 1'b0;
         pulse_q       <= 1'b0;
      end else begin
         if (issue) begin
            if (!tvalid_q || m_axis_config_tready) begin
               tdata_q  <= issue_word;
               tvalid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (tvalid_q && m_axis_config_tready) begin
            tvalid_q <= 1'b0;
         end

         if (start_pulse) begin
            state_q       <= PULSE;
            code_q        <= code_sel_i;
            chip_cycles_q <= chip_cycles_i;
            period_q      <= period_i;
            pinc_q        <= pinc_i;
            pulse_q       <= 1'b1;
            chip_idx_q    <= '0;
            chip_cnt_q    <= '0;
            period_cnt_q  <= '0;
         end else if (state_q != IDLE) begin
            if (!enable_i) begin
               state_q      <= IDLE;
               pulse_q      <= 1'b0;
               chip_idx_q   <= '0;
               chip_cnt_q   <= '0;
               period_cnt_q <= '0;
            end else begin
               if (period_cnt_q != '1) period_cnt_q <= period_cnt_q + PERIOD_COUNTER_BITS'(1);
               if (state_q == PULSE) begin
                  if (chip_end) begin
                     chip_cnt_q <= '0;
                     if (last_chip) begin
                        state_q    <= GAP;
                        pulse_q    <= 1'b0;
                        chip_idx_q <= '0;
                     end else begin
                        chip_idx_q <= chip_idx_q + 4'd1;
                     end
                  end else begin
                     chip_cnt_q <= chip_cnt_q + CHIP_CNT_BITS'(1);
                  end
               end
            end
         end
      end
   end

   assign m_axis_config_tdata  = tdata_q;
   assign m_axis_config_tvalid = tvalid_q;
   assign pulse_o              = pulse_q;
   assign chip_idx_o           = chip_idx_q;
   assign overrun_o            = overrun_q;
   assign busy_o               = (state_q != IDLE);

`ifdef PULSE_COUNTER_EN
   logic [31:0] pulse_count_q;
   logic        pulse_done_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         pulse_count_q <= '0;
         pulse_done_q  <= 1'b0;
      end else if (!enable_i && (state_q != IDLE)) begin
         pulse_count_q <= '0;
         pulse_done_q  <= 1'b0;
      end else if (enable_i && chip_end && last_chip) begin
         pulse_count_q <= pulse_count_q + 32'd1;
         pulse_done_q  <= 1'b1;
      end else begin
         pulse_done_q  <= 1'b0;
      end
   end

   assign pulse_count_o = pulse_count_q;
   assign pulse_done_o  = pulse_done_q;
`endif

endmodule

// File: tb/tb_barker_phase_sequencer.sv
// tb/tb_barker_phase_sequencer.sv - Directed bench for barker_phase_sequencer.
// Also covers the PULSE_COUNTER_EN outputs when that macro is defined.
module tb_barker_phase_sequencer;

   localparam logic [29:0] OFF = 30'd536870911;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  code_sel = 3'd0;
   logic [15:0] chip_cycles = 16'd1;
   logic [14:0] period = 15'd100;
   logic [29:0] pinc = 30'd0;
   logic [63:0] tdata;
   logic        tvalid;
   logic        tready = 1'b1;
   logic        pulse;
   logic [3:0]  chip_idx;
   logic        overrun;
   logic        busy;
`ifdef PULSE_COUNTER_EN
   logic [31:0] pulse_count;
   logic        pulse_done;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [63:0] hs_q[$];
   int          hs_cyc[$];

   barker_phase_sequencer dut (
      .aclk                 (clk),
      .aresetn              (aresetn),
      .enable_i             (enable),
      .code_sel_i           (code_sel),
      .chip_cycles_i        (chip_cycles),
      .period_i             (period),
      .pinc_i               (pinc),
      .m_axis_config_tdata  (tdata),
      .m_axis_config_tvalid (tvalid),
      .m_axis_config_tready (tready),
      .pulse_o              (pulse),
      .chip_idx_o           (chip_idx),
      .overrun_o            (overrun),
      .busy_o               (busy)
`ifdef PULSE_COUNTER_EN
      ,
      .pulse_count_o        (pulse_count),
      .pulse_done_o         (pulse_done)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      if (tvalid && tready) begin
         hs_q.push_back(tdata);
         hs_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  cs;
      logic [15:0] cc;
      logic [29:0] pinc;
      int          n;
      int          sp;
      logic [12:0] pat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] word(input logic [12:0] pat, input int k, input logic [29:0] p);
      logic [12:0] t;
      t = pat << k;
      return {2'b00, (t[12] ? 30'd0 : OFF), 2'b00, p};
   endfunction

   task automatic do_reset();
      aresetn = 1'b0;
      enable  = 1'b0;
      tready  = 1'b1;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
   endtask

   initial begin
      vecs[0] = '{3'd0, 16'd2, 30'h0001234, 2,  2, 13'b1000000000000};
      vecs[1] = '{3'd1, 16'd1, 30'h0000abc, 3,  1, 13'b1100000000000};
      vecs[2] = '{3'd2, 16'd3, 30'h0055555, 4,  3, 13'b1101000000000};
      vecs[3] = '{3'd3, 16'd4, 30'h1000000, 5,  4, 13'b1110100000000};
      vecs[4] = '{3'd4, 16'd2, 30'h0000777, 7,  2, 13'b1110010000000};
      vecs[5] = '{3'd5, 16'd1, 30'h2000000, 11, 1, 13'b1110001001000};
      vecs[6] = '{3'd6, 16'd2, 30'h3ffffff, 13, 2, 13'b1111100110101};
      vecs[7] = '{3'd7, 16'd0, 30'h0000001, 1,  1, 13'b1000000000000};

      // Reset state
      aresetn = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_tdata", tdata, 64'd0);
      check("reset_tvalid", 64'(tvalid), 64'd0);
      check("reset_pulse", 64'(pulse), 64'd0);
      check("reset_chip_idx", 64'(chip_idx), 64'd0);
      check("reset_overrun", 64'(overrun), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      aresetn = 1'b1;

      // One pulse per code: word count, every word, chip spacing
      for (int v = 0; v < 8; v++) begin
         do_reset();
         code_sel    = vecs[v].cs;
         chip_cycles = vecs[v].cc;
         pinc        = vecs[v].pinc;
         period      = 15'd200;
         hs_q.delete();
         hs_cyc.delete();
         enable = 1'b1;
         repeat (vecs[v].n * vecs[v].sp + 4) @(negedge clk);
         enable = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("code%0d_words", v), 64'(hs_q.size()), 64'(vecs[v].n));
         for (int k = 0; k < hs_q.size() && k < vecs[v].n; k++)
            check($sformatf("code%0d_word%0d", v, k), hs_q[k], word(vecs[v].pat, k, vecs[v].pinc));
         if (hs_q.size() >= 2)
            check($sformatf("code%0d_spacing", v), 64'(hs_cyc[1] - hs_cyc[0]), 64'(vecs[v].sp));
      end

      // B5 pulse width and repetition period
      begin
         int rises[$];
         int width = 0;
         bit first_done = 0;
         bit prev = 0;
         do_reset();
         code_sel = 3'd3; chip_cycles = 16'd4; period = 15'd100; pinc = 30'h1000000;
         enable = 1'b1;
         for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (pulse && !prev) rises.push_back(i);
            if (pulse && !first_done) width++;
            if (!pulse && prev) first_done = 1;
            prev = pulse;
         end
         enable = 1'b0;
         check("b5_pulse_width", 64'(width), 64'd20);
         check("b5_rise_count", 64'(rises.size()), 64'd2);
         if (rises.size() >= 2) check("b5_period", 64'(rises[1] - rises[0]), 64'd100);
      end

      // B13 back-to-back pulses, one word per cycle
      begin
         int lows = 0;
         logic [12:0] p13;
         p13 = 13'b1111100110101;
         do_reset();
         code_sel = 3'd6; chip_cycles = 16'd1; period = 15'd10; pinc = 30'h0000042;
         hs_q.delete(); hs_cyc.delete();
         enable = 1'b1;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!pulse) lows++;
         end
         enable = 1'b0;
         repeat (2) @(negedge clk);
         check("b13_pulse_low_cycles", 64'(lows), 64'd0);
         check("b13_words", 64'(hs_q.size()), 64'd40);
         if (hs_q.size() == 40) begin
            check("b13_contiguous", 64'(hs_cyc[39] - hs_cyc[0]), 64'd39);
            for (int k = 0; k < 40; k++)
               check($sformatf("b13_word%0d", k), hs_q[k], word(p13, k % 13, 30'h0000042));
         end
      end

      // Overrun: B3, first word held while tready is low
      begin
         logic [12:0] p3;
         logic [63:0] w0, w2;
         p3 = 13'b1100000000000;
         w0 = word(p3, 0, 30'h0000099);
         w2 = word(p3, 2, 30'h0000099);
         do_reset();
         code_sel = 3'd1; chip_cycles = 16'd2; period = 15'd200; pinc = 30'h0000099;
         hs_q.delete(); hs_cyc.delete();
         tready = 1'b0;
         enable = 1'b1;
         @(negedge clk);
         check("ovr_first_valid", 64'(tvalid), 64'd1);
         check("ovr_first_word", tdata, w0);
         @(negedge clk);
         check("ovr_hold_word", tdata, w0);
         @(negedge clk);
         check("ovr_flag", 64'(overrun), 64'd1);
         check("ovr_held_after_drop", tdata, w0);
         tready = 1'b1;
         repeat (6) @(negedge clk);
         enable = 1'b0;
         @(negedge clk);
         check("ovr_accepted_count", 64'(hs_q.size()), 64'd2);
         if (hs_q.size() == 2) begin
            check("ovr_accepted0", hs_q[0], w0);
            check("ovr_accepted1", hs_q[1], w2);
         end
         check("ovr_sticky", 64'(overrun), 64'd1);
      end

      // Disable during chip 3 of B7 with a word pending
      begin
         logic [12:0] p7;
         logic [63:0] w3;
         int guard = 0;
         int extra = 0;
         p7 = 13'b1110010000000;
         w3 = word(p7, 3, 30'h0000123);
         do_reset();
         code_sel = 3'd4; chip_cycles = 16'd8; period = 15'd200; pinc = 30'h0000123;
         hs_q.delete(); hs_cyc.delete();
         enable = 1'b1;
         @(negedge clk);
         while (chip_idx != 4'd3 && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         check("dis_reached_chip3", 64'(chip_idx), 64'd3);
         tready = 1'b0;
         enable = 1'b0;
         @(negedge clk);
         check("dis_pulse", 64'(pulse), 64'd0);
         check("dis_busy", 64'(busy), 64'd0);
         check("dis_chip_idx", 64'(chip_idx), 64'd0);
         check("dis_pending_valid", 64'(tvalid), 64'd1);
         check("dis_pending_word", tdata, w3);
         tready = 1'b1;
         @(negedge clk);
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tvalid) extra++;
         end
         check("dis_no_more_valid", 64'(extra), 64'd0);
         check("dis_words", 64'(hs_q.size()), 64'd4);
         if (hs_q.size() == 4) check("dis_last_word", hs_q[3], w3);
      end

      // Reset pulse during GAP clears state, including overrun, then restarts
      begin
         int guard = 0;
         logic [63:0] w0;
         w0 = word(13'b1110100000000, 0, 30'h1000000);
         do_reset();
         code_sel = 3'd3; chip_cycles = 16'd4; period = 15'd100; pinc = 30'h1000000;
         tready = 1'b0;
         enable = 1'b1;
         repeat (6) @(negedge clk);
         tready = 1'b1;
         check("rst_overrun_before", 64'(overrun), 64'd1);
         while (!(busy && !pulse) && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         check("rst_in_gap", 64'(busy && !pulse), 64'd1);
         aresetn = 1'b0;
         @(negedge clk);
         aresetn = 1'b1;
         check("rst_tdata", tdata, 64'd0);
         check("rst_tvalid", 64'(tvalid), 64'd0);
         check("rst_pulse", 64'(pulse), 64'd0);
         check("rst_overrun", 64'(overrun), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         @(negedge clk);
         check("rst_restart_pulse", 64'(pulse), 64'd1);
         check("rst_restart_chip", 64'(chip_idx), 64'd0);
         check("rst_restart_word", tdata, w0);
         enable = 1'b0;
         repeat (2) @(negedge clk);
      end

`ifdef PULSE_COUNTER_EN
      // Uncoded, 3 cycles per chip, period 6: count and strobe spacing
      begin
         int dones[$];
         int guard = 0;
         do_reset();
         code_sel = 3'd7; chip_cycles = 16'd3; period = 15'd6; pinc = 30'h0000010;
         enable = 1'b1;
         while (dones.size() < 10 && guard < 200) begin
            @(negedge clk);
            if (pulse_done) dones.push_back(guard);
            guard++;
         end
         check("cnt_strobes", 64'(dones.size()), 64'd10);
         check("cnt_value", 64'(pulse_count), 64'd10);
         for (int i = 1; i < dones.size(); i++)
            check($sformatf("cnt_spacing%0d", i), 64'(dones[i] - dones[i-1]), 64'd6);
         enable = 1'b0;
         repeat (2) @(negedge clk);
         check("cnt_cleared_idle", 64'(pulse_count), 64'd0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
